// File: rtl/step_pkg.sv
// Shared definitions for the step command encoder and the modulo-10 step counter.
package step_pkg;

  typedef logic [1:0] step_cmd_t;
  typedef logic [1:0] step_state_t;

  localparam step_cmd_t CMD_HOLD = 2'b00;
  localparam step_cmd_t CMD_INC1 = 2'b01;
  localparam step_cmd_t CMD_INC2 = 2'b10;
  localparam step_cmd_t CMD_DEC  = 2'b11;

  localparam step_state_t ST_IDLE     = 2'd0;
  localparam step_state_t ST_QUAL     = 2'd1;
  localparam step_state_t ST_FIRE     = 2'd2;
  localparam step_state_t ST_WAIT_REL = 2'd3;

  // Button vector order is {dec, inc2, inc1}.
  function automatic step_cmd_t cmd_for(input logic [2:0] btn);
    step_cmd_t cmd;
    cmd = CMD_HOLD;
    case (btn)
      3'b001:  cmd = CMD_INC1;
      3'b010:  cmd = CMD_INC2;
      3'b100:  cmd = CMD_DEC;
      default: cmd = CMD_HOLD;
    endcase
    return cmd;
  endfunction

  function automatic logic is_one_hot(input logic [2:0] btn);
    return (btn == 3'b001) || (btn == 3'b010) || (btn == 3'b100);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_command_encoder.sv
// Debounces three pushbuttons and issues one single-cycle w1/w0 step command per
// qualified press; multi-button presses raise a one-cycle conflict pulse instead.
module step_command_encoder
  import step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn_inc1,
  input  logic btn_inc2,
  input  logic btn_dec,
  output logic w1,
  output logic w0,
  output logic conflict
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       s;
  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;
  step_state_t      state;
  step_cmd_t        cmd_q;
  logic             conflict_q;

  sync_2ff #(.WIDTH(3)) u_sync (
    .Clock (Clock),
    .Reset (Reset),
    .d     ({btn_dec, btn_inc2, btn_inc1}),
    .q     (s)
  );

  // Reset lands in WAIT_REL so a button held through reset must be released first.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_WAIT_REL;
      cand       <= '0;
      cnt        <= '0;
      cmd_q      <= CMD_HOLD;
      conflict_q <= 1'b0;
    end else begin
      cmd_q      <= CMD_HOLD;
      conflict_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s != 3'b000) begin
            cand  <= s;
            cnt   <= '0;
            state <= ST_QUAL;
          end
        end
        ST_QUAL: begin
          if (s != cand) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            if (is_one_hot(cand)) begin
              state <= ST_FIRE;
              cmd_q <= cmd_for(cand);
            end else begin
              state      <= ST_WAIT_REL;
              cnt        <= '0;
              conflict_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_FIRE: begin
          state <= ST_WAIT_REL;
          cnt   <= '0;
        end
        ST_WAIT_REL: begin
          if (s != 3'b000) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= ST_WAIT_REL;
      endcase
    end
  end

  assign w1       = cmd_q[1];
  assign w0       = cmd_q[0];
  assign conflict = conflict_q;

endmodule

// File: doc/step_command_encoder.md
# step_command_encoder

Upstream front end for the modulo-10 step counter. It takes three raw pushbuttons (step +1, step +2, step −1) and synchronizes and debounces them. It then issues exactly one single-cycle w1/w0 step command per qualified press, so the counter advances once per press rather than once per clock. Between presses it drives the hold code 00; multi-button presses are rejected and flagged.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to qualify a press or a release; legal range ≥1.
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high.
- btn_inc1  input  1  raw button, active-high, asynchronous to Clock.
- btn_inc2  input  1  raw button, active-high, asynchronous.
- btn_dec  input  1  raw button, active-high, asynchronous.
- w1  output  1  command MSB, registered.
- w0  output  1  command LSB, registered.
- conflict  output  1  one-cycle pulse when a qualified press has more than one button asserted; registered.

## Operation
- Command codes {w1,w0}:
  - 00 hold
  - 01 inc1
  - 10 inc2
  - 11 dec
- Each button passes through 2-flop synchronizer; s[2:0] = {dec,inc2,inc1} synchronized vector.
- Registers: state, cand[2:0] (latched vector), cnt (width clog2(DEBOUNCE_CYCLES+1)).
- States and transitions (evaluated each edge, Reset low):
  - IDLE: s≠0 → cand<=s, cnt<=0, QUAL; else stay.
  - QUAL: s≠cand → IDLE (bounce or change, discard). If s==cand and cnt==DEBOUNCE_CYCLES−1:
    - cand one-hot → FIRE; {w1,w0}<=code(cand).
    - Otherwise → WAIT_REL, cnt<=0; conflict<=1.
  - QUAL, none of the above: cnt++.
  - FIRE: one cycle; → WAIT_REL, cnt<=0; {w1,w0}<=00.
  - WAIT_REL: s≠0 → cnt<=0, stay. s==0 and cnt==DEBOUNCE_CYCLES−1 → IDLE. Otherwise cnt++.
- {w1,w0} is nonzero only during the single cycle after entry into FIRE. conflict is high only in the cycle after the QUAL→WAIT_REL conflict transition.
- Buttons added, removed or changed while in WAIT_REL never generate a command. All buttons must be released for DEBOUNCE_CYCLES cycles first.
- Reset (any state, any cycle):
  - Synchronizer flops <= 0, cand <= 0, cnt <= 0.
  - w1=w0=0, conflict=0.
  - State <= WAIT_REL, so a button held through reset cannot fire.
  - After reset release, DEBOUNCE_CYCLES cycles of s==0 are needed before IDLE.
- Reset takes priority over every transition; a pending FIRE is cancelled.

## Timing
- Press latency: raw button sampled high at edge E (first sync flop). Timing, with the button stable and the block in IDLE:
  - s becomes high after edge E+1.
  - QUAL is entered at E+2.
  - FIRE is entered at E+2+DEBOUNCE_CYCLES.
  - The command is visible for exactly one cycle following that edge.
- With DEBOUNCE_CYCLES=4, the command appears after edge E+6 and returns to 00 after E+7.
- Minimum press-to-press spacing: release qualification (DEBOUNCE_CYCLES) plus press qualification. Back-to-back commands are never adjacent cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package step_pkg holds:
  - Command constants CMD_HOLD=2'b00, CMD_INC1=2'b01, CMD_INC2=2'b10, CMD_DEC=2'b11, also consumed by the modulo-10 counter.
  - The state encoding IDLE/QUAL/FIRE/WAIT_REL (2 bits).
- Sub-module: sync_2ff, parameterized WIDTH (here 3), synchronous reset to 0.
- FSM, counter and output registers live in step_command_encoder.

## Test plan
- Reset, wait 10 cycles, hold btn_inc1 for 20 cycles (DEBOUNCE_CYCLES=4) → {w1,w0}=01 for exactly one cycle, 6 edges after first sample; 00 otherwise; conflict never high.
- btn_inc2 bouncing with 2-cycle highs and 1-cycle lows for 12 cycles, then stable 10 cycles → no command during the bounce, then one 10 pulse.
- btn_inc1 and btn_dec pressed together for 10 cycles → conflict pulses once, w stays 00. Release 6 cycles, then btn_dec alone → one 11 pulse.
- btn_dec held high across Reset deassertion for 30 cycles → no command. Release 6 cycles, press again → one 11 pulse.
- Reset asserted during the QUAL cycle with cnt=2 → outputs 00 next cycle, no command ever issued for that press.
- Hold btn_inc1 until its 01 pulse, then add btn_inc2 while still holding → no further command or conflict until full release and re-press.
